// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - two-stage bitwise logic pipeline with valid/ready handshakes and delivery counter
module logic_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [1:0]       op1_i,
    input  logic [1:0]       op2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] e_o,
    output logic [CNT_W-1:0] count_o
);

    // 00 AND, 01 OR, 10 XOR, 11 NAND
    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            default: r = ~(x & y);
        endcase
        return r;
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_c;
    logic [WIDTH-1:0] s1_d;
    logic [1:0]       s1_op2;

    logic s2_ready;
    logic in_hs;
    logic s2_load;
    logic out_hs;

    // Stage 2 can take new data when empty or when its result leaves this cycle;
    // stage 1 can then always drain, so the input sees a purely combinational stall.
    always_comb begin
        s2_ready = !valid_o || ready_i;
        ready_o  = !s1_valid || s2_ready;
        in_hs    = valid_i && ready_o;
        s2_load  = s1_valid && s2_ready;
        out_hs   = valid_o && ready_i;
    end

    // Stage 1: capture C = op1(A,B) with D and op2 carried along for stage 2
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_c     <= '0;
            s1_d     <= '0;
            s1_op2   <= 2'b00;
        end else if (in_hs) begin
            s1_valid <= 1'b1;
            s1_c     <= apply_op(op1_i, a_i, b_i);
            s1_d     <= d_i;
            s1_op2   <= op2_i;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: produce E = op2(C,D) and hold it until the downstream accepts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            e_o     <= '0;
        end else if (s2_load) begin
            valid_o <= 1'b1;
            e_o     <= apply_op(s1_op2, s1_c, s1_d);
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

    // Count delivered results, wrapping naturally at the counter width
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (out_hs) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_logic_pipe.sv
// tb/tb_logic_pipe.sv - self-checking bench for logic_pipe with transaction-level model
module tb_logic_pipe;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       rdy;
    logic [7:0] a, b, d;
    logic [1:0] op1, op2;
    logic       ready_o, valid_o;
    logic [7:0] e_o;
    logic [3:0] count_o;

    logic        v1, a1, b1, d1, rdy1;
    logic [1:0]  op1_1, op2_1;
    logic        ready1_o, valid1_o, e1_o;
    logic [15:0] count1_o;

    int checks = 0;
    int errors = 0;

    logic_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready_o),
        .a_i(a), .b_i(b), .d_i(d), .op1_i(op1), .op2_i(op2),
        .valid_o(valid_o), .ready_i(rdy), .e_o(e_o), .count_o(count_o)
    );

    logic_pipe #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(ready1_o),
        .a_i(a1), .b_i(b1), .d_i(d1), .op1_i(op1_1), .op2_i(op2_1),
        .valid_o(valid1_o), .ready_i(rdy1), .e_o(e1_o), .count_o(count1_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] op_f(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // Transaction model: in-flight results in acceptance order, each tagged with its accept edge
    typedef struct {
        logic [7:0] e;
        int         acc;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   m_count = 0;
    bit   armed = 0;

    function automatic bit model_valid();
        return (q.size() > 0) && (cyc - q[0].acc >= 2);
    endfunction

    function automatic bit model_ready();
        return (q.size() < 2) || rdy;
    endfunction

    initial forever begin
        bit ev, er;
        @(posedge clk);
        ev = model_valid();
        er = model_ready();
        if (rst) begin
            q.delete();
            m_count = 0;
            armed = 1;
        end else begin
            if (ev && rdy) begin
                void'(q.pop_front());
                m_count = (m_count + 1) % 16;
            end
            if (valid && er)
                q.push_back('{e: op_f(op2, op_f(op1, a, b), d), acc: cyc});
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("valid_o", valid_o, model_valid());
            chk("ready_o", ready_o, model_ready());
            chk("count_o", count_o, m_count);
            if (model_valid())
                chk("e_o", e_o, q[0].e);
        end
    end

    initial begin
        int         idx, ndel, n1;
        bit         hs, seen;
        logic [7:0] got[8];
        logic       res1[16];
        int         cyc1[16];
        logic [7:0] exp_bits;

        rst = 1; valid = 0; rdy = 1; a = 0; b = 0; d = 0; op1 = 2'd0; op2 = 2'd1;
        v1 = 0; a1 = 0; b1 = 0; d1 = 0; rdy1 = 1; op1_1 = 2'd0; op2_1 = 2'd1;
        tick(); tick();
        rst = 0;
        chk("rst_valid", valid_o, 0);
        chk("rst_e", e_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ready", ready_o, 1);

        // basic latency with default ops: (F0 & 3C) | 01 = 31
        valid = 1; a = 8'hF0; b = 8'h3C; d = 8'h01; op1 = 2'd0; op2 = 2'd1;
        tick();
        valid = 0;
        chk("lat_n", valid_o, 0);
        tick();
        chk("lat_n1_valid", valid_o, 1);
        chk("lat_n1_e", e_o, 8'h31);
        tick();
        chk("lat_count", count_o, 1);
        chk("lat_drained", valid_o, 0);

        // XOR then NAND; ops changed afterwards without a handshake must not matter
        valid = 1; a = 8'hAA; b = 8'h55; d = 8'h0F; op1 = 2'd2; op2 = 2'd3;
        tick();
        valid = 0; op1 = 2'd0; op2 = 2'd1;
        tick();
        chk("xor_nand_e", e_o, 8'hF0);
        chk("xor_nand_valid", valid_o, 1);
        tick();

        // backpressure: only two held, head stable, then drained in order exactly once
        rdy = 0; a = 0; b = 0; op1 = 2'd0; op2 = 2'd1; idx = 1;
        for (int t = 0; t < 6; t++) begin
            valid = (idx <= 4); d = 8'(idx);
            @(negedge clk);
            hs = ready_o && valid;
            tick();
            if (hs) idx++;
        end
        chk("bp_next_idx", idx, 3);
        chk("bp_ready", ready_o, 0);
        chk("bp_valid", valid_o, 1);
        chk("bp_hold_e", e_o, 8'h01);
        rdy = 1; ndel = 0;
        for (int t = 0; t < 50 && ndel < 4; t++) begin
            valid = (idx <= 4); d = 8'(idx);
            @(negedge clk);
            hs = ready_o && valid;
            if (valid_o) begin
                got[ndel] = e_o;
                ndel++;
            end
            tick();
            if (hs) idx++;
        end
        valid = 0;
        chk("bp_delivered", ndel, 4);
        for (int k = 0; k < 4; k++)
            chk("bp_order", got[k], 8'(k + 1));
        repeat (3) tick();
        chk("bp_no_dup", valid_o, 0);

        // mixed stream with intermittent valid/ready and varying ops
        for (int t = 0; t < 40; t++) begin
            valid = (t % 5 != 3);
            rdy   = (t % 7 != 2) && (t % 7 != 3);
            a = 8'(t * 37); b = 8'(t * 91 + 5); d = 8'(t * 13);
            op1 = 2'(t % 4); op2 = 2'((t / 3) % 4);
            tick();
        end
        valid = 0; rdy = 1;
        repeat (4) tick();

        // counter wrap with a 4-bit counter: 17 deliveries leave 1
        rst = 1; tick(); rst = 0;
        op1 = 2'd0; op2 = 2'd1; b = 8'hFF; d = 0;
        for (int k = 0; k < 17; k++) begin
            valid = 1; a = 8'(k);
            tick();
        end
        valid = 0;
        repeat (4) tick();
        chk("cnt_wrap", count_o, 1);

        // reset with two in flight: discarded, nothing until a new transaction
        rdy = 0; valid = 1; a = 0; b = 0; d = 8'h11;
        tick();
        d = 8'h22;
        tick();
        rst = 1; d = 8'h33;
        tick();
        rst = 0; valid = 0;
        chk("rst2_valid", valid_o, 0);
        chk("rst2_count", count_o, 0);
        chk("rst2_ready", ready_o, 1);
        rdy = 1; seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid_o) seen = 1;
            tick();
        end
        chk("rst2_silent", seen, 0);
        valid = 1; d = 8'h44;
        tick();
        valid = 0;
        chk("rst2_new_n", valid_o, 0);
        tick();
        chk("rst2_new_valid", valid_o, 1);
        chk("rst2_new_e", e_o, 8'h44);
        tick();

        // WIDTH=1: all eight (a,b,d) combos back-to-back, (a&b)|d per combo
        exp_bits = 8'b1110_1010;
        n1 = 0;
        for (int t = 0; t < 12; t++) begin
            v1 = (t < 8);
            {a1, b1, d1} = (t < 8) ? 3'(t) : 3'd0;
            @(negedge clk);
            if (valid1_o && n1 < 16) begin
                res1[n1] = e1_o;
                cyc1[n1] = t;
                n1++;
            end
            tick();
        end
        chk("w1_count", n1, 8);
        chk("w1_first_cycle", cyc1[0], 2);
        for (int k = 0; k < 8 && k < n1; k++) begin
            chk("w1_result", res1[k], exp_bits[k]);
            chk("w1_back_to_back", cyc1[k], cyc1[0] + k);
        end
        chk("w1_count_o", count1_o, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
